// File: rtl/r_response_memory_pkg.sv
// Shared types and default sizing for the R-channel response memory.
package rob_pkg;

  localparam int unsigned ROW_W      = 2;
  localparam int unsigned COL_W      = 2;
  localparam int unsigned ID_WIDTH   = ROW_W + COL_W;
  localparam int unsigned DATA_WIDTH = 64;
  localparam int unsigned RESP_WIDTH = 2;
  localparam int unsigned MAX_LEN    = 8;
  localparam int unsigned DEPTH      = 32;
  localparam int unsigned SLOT_W     = $clog2(DEPTH);

  typedef logic [ROW_W+COL_W-1:0] uid_t;
  typedef logic [SLOT_W-1:0]      slot_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [RESP_WIDTH-1:0] resp;
    logic                  last;
  } r_beat_t;

  // Compose a unique id from its row and column parts.
  function automatic uid_t make_uid(input logic [ROW_W-1:0] row,
                                    input logic [COL_W-1:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/r_response_memory_if.sv
// R-channel beat bus: one beat per valid/ready handshake.
interface r_if #(
  parameter int unsigned ID_WIDTH   = rob_pkg::ID_WIDTH,
  parameter int unsigned DATA_WIDTH = rob_pkg::DATA_WIDTH,
  parameter int unsigned RESP_WIDTH = rob_pkg::RESP_WIDTH
);
  logic                  valid;
  logic                  ready;
  logic [ID_WIDTH-1:0]   id;
  logic [DATA_WIDTH-1:0] data;
  logic [RESP_WIDTH-1:0] resp;
  logic                  last;

  modport sender   (output valid, id, data, resp, last, input  ready);
  modport receiver (input  valid, id, data, resp, last, output ready);
endinterface

// File: rtl/r_response_memory_slot_alloc.sv
// Slot pool bookkeeping: free bitmap, lowest-free allocation, occupancy.
module rm_slot_alloc
  import rob_pkg::*;
#(
  parameter int unsigned DEPTH = rob_pkg::DEPTH,
  localparam int unsigned SW   = $clog2(DEPTH),
  localparam int unsigned OW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alloc_en,
  input  logic          free_en,
  input  logic [SW-1:0] free_idx,
  output logic [SW-1:0] alloc_idx,
  output logic [OW-1:0] occupancy,
  output logic          full
);

  logic [DEPTH-1:0] slot_free;

  // Lowest-index free slot; descending scan so the lowest match wins.
  always_comb begin
    alloc_idx = '0;
    for (int unsigned i = DEPTH; i > 0; i--) begin
      if (slot_free[i-1]) alloc_idx = SW'(i - 1);
    end
  end

  // Free bitmap: allocated and released slots are always distinct.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_free <= '1;
    end else begin
      if (free_en)  slot_free[free_idx]  <= 1'b1;
      if (alloc_en) slot_free[alloc_idx] <= 1'b0;
    end
  end

  // Occupancy counter: concurrent alloc and free cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occupancy <= '0;
    end else begin
      case ({alloc_en, free_en})
        2'b10:   occupancy <= occupancy + OW'(1);
        2'b01:   occupancy <= occupancy - OW'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

  assign full = (occupancy == OW'(DEPTH));

endmodule

// File: rtl/r_response_memory.sv
// Response memory: per-uid FIFO lists of R beats threaded through a shared slot pool.
module r_response_memory
  import rob_pkg::*;
#(
  parameter int unsigned ID_WIDTH   = rob_pkg::ID_WIDTH,
  parameter int unsigned DATA_WIDTH = rob_pkg::DATA_WIDTH,
  parameter int unsigned RESP_WIDTH = rob_pkg::RESP_WIDTH,
  parameter int unsigned MAX_LEN    = rob_pkg::MAX_LEN,
  parameter int unsigned DEPTH      = rob_pkg::DEPTH,
  localparam int unsigned OW        = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  r_if.receiver               r_store,
  input  logic [ID_WIDTH-1:0] rm_release_uid,
  r_if.sender                 r_release,
  output logic [OW-1:0]       rm_occupancy,
  output logic                rm_full
);

  localparam int unsigned NUM_UIDS = 2 ** ID_WIDTH;
  localparam int unsigned SW       = $clog2(DEPTH);
  localparam int unsigned CW       = $clog2(MAX_LEN + 1);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [RESP_WIDTH-1:0] resp;
    logic                  last;
  } beat_t;

  beat_t         pool     [DEPTH];
  logic [SW-1:0] next_ptr [DEPTH];
  logic [SW-1:0] head     [NUM_UIDS];
  logic [SW-1:0] tail     [NUM_UIDS];
  logic [CW-1:0] cnt      [NUM_UIDS];

  logic [ID_WIDTH-1:0] store_uid;
  logic [SW-1:0]       alloc_idx;
  logic [SW-1:0]       rel_head;
  logic                hs_store;
  logic                hs_release;
  logic                same_uid_both;

  assign store_uid     = r_store.id;
  assign rel_head      = head[rm_release_uid];
  assign hs_store      = r_store.valid & r_store.ready;
  assign hs_release    = r_release.valid & r_release.ready;
  assign same_uid_both = hs_store & hs_release & (store_uid == rm_release_uid);

  rm_slot_alloc #(
    .DEPTH (DEPTH)
  ) u_slot_alloc (
    .clk       (clk),
    .rst       (rst),
    .alloc_en  (hs_store),
    .free_en   (hs_release),
    .free_idx  (rel_head),
    .alloc_idx (alloc_idx),
    .occupancy (rm_occupancy),
    .full      (rm_full)
  );

  // Store readiness depends only on registered occupancy and the addressed uid count.
  always_comb begin
    r_store.ready = ~rst & ~rm_full & (cnt[store_uid] != CW'(MAX_LEN));
  end

  // Zero-latency release view of the named uid's oldest beat.
  always_comb begin
    r_release.valid = ~rst & (cnt[rm_release_uid] != '0);
    r_release.id    = rm_release_uid;
    r_release.data  = 'x;
    r_release.resp  = 'x;
    r_release.last  = 'x;
    if (r_release.valid) begin
      r_release.data = pool[rel_head].data;
      r_release.resp = pool[rel_head].resp;
      r_release.last = pool[rel_head].last;
    end
  end

  // Beat payload and list links; deliberately not reset.
  always_ff @(posedge clk) begin
    if (hs_store) begin
      pool[alloc_idx] <= '{data: r_store.data, resp: r_store.resp, last: r_store.last};
      if (cnt[store_uid] != '0) next_ptr[tail[store_uid]] <= alloc_idx;
    end
  end

  // Per-uid list heads, tails and counts. The store branch runs last so it
  // overrides the release branch when both target one uid: a single-entry
  // list then restarts at the new slot and the count is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned u = 0; u < NUM_UIDS; u++) begin
        head[u] <= '0;
        tail[u] <= '0;
        cnt[u]  <= '0;
      end
    end else begin
      if (hs_release) begin
        head[rm_release_uid] <= next_ptr[rel_head];
        cnt[rm_release_uid]  <= cnt[rm_release_uid] - CW'(1);
      end
      if (hs_store) begin
        tail[store_uid] <= alloc_idx;
        if (cnt[store_uid] == '0 || (same_uid_both && cnt[store_uid] == CW'(1)))
          head[store_uid] <= alloc_idx;
        cnt[store_uid] <= same_uid_both ? cnt[store_uid] : cnt[store_uid] + CW'(1);
      end
    end
  end

endmodule
